// File: rtl/definitions_pkg.sv
// Shared UART receive-path definitions: line rates and the framer state encoding.
package definitions_pkg;

   localparam int unsigned CLOCK_RATE = 50_000_000;
   localparam int unsigned BAUD_RATE  = 115_200;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA      = 2'd1,
      STOP      = 2'd2,
      WAIT_IDLE = 2'd3
   } rx_state_e;

endpackage : definitions_pkg

// File: rtl/uart_rx_framer.sv
// UART receive framer: turns synchronized baud sample toggles and line level into
// bytes with a valid/ready handshake, stop-bit checking and an in-frame watchdog.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a sample strobe that sees the start bit (line=0)
// DATA      | shifting DATA_BITS data bits in, LSB first
// STOP      | expecting the stop bit (line=1) on the next strobe
// WAIT_IDLE | after a bad stop bit, hold off until a strobe sees line=1
module uart_rx_framer
   import definitions_pkg::*;
#(
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 2 * (CLOCK_RATE / BAUD_RATE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud,
   input  logic                 line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W  = $clog2(DATA_BITS + 1);
   localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DATA_BITS);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || TIMEOUT_CYCLES < CLOCK_RATE / BAUD_RATE) begin : g_param_check
      $fatal(1, "uart_rx_framer: DATA_BITS must be 5..9 and TIMEOUT_CYCLES at least one bit period");
   end

   rx_state_e            state;
   rx_state_e            state_nxt;
   logic                 baud_q;
   logic                 armed;
   logic                 strobe;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic [WDOG_W-1:0]    wdog;
   logic                 in_frame;
   logic                 start_frame;
   logic                 shift_bit;
   logic                 complete;
   logic                 stop_err;
   logic                 expire;
   logic                 load;

   // armed holds off the first post-reset cycle, where baud_q is still at its reset value
   assign strobe   = armed && (baud != baud_q);
   assign in_frame = (state == DATA) || (state == STOP);
   assign load     = complete && (!rx_valid || rx_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A strobe is checked before the watchdog so a sample landing on the expiry cycle wins
   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      shift_bit   = 1'b0;
      complete    = 1'b0;
      stop_err    = 1'b0;
      expire      = 1'b0;
      case (state)
         IDLE: begin
            if (strobe && !line) begin
               state_nxt   = DATA;
               start_frame = 1'b1;
            end
         end
         DATA: begin
            if (strobe) begin
               shift_bit = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = STOP;
               end
            end else if (wdog == WDOG_LAST) begin
               state_nxt = IDLE;
               expire    = 1'b1;
            end
         end
         STOP: begin
            if (strobe) begin
               if (line) begin
                  state_nxt = IDLE;
                  complete  = 1'b1;
               end else begin
                  state_nxt = WAIT_IDLE;
                  stop_err  = 1'b1;
               end
            end else if (wdog == WDOG_LAST) begin
               state_nxt = IDLE;
               expire    = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (strobe && line) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q    <= 1'b0;
         armed     <= 1'b0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         wdog      <= '0;
      end else begin
         baud_q <= baud;
         armed  <= 1'b1;

         if (start_frame) begin
            bit_cnt <= '0;
         end else if (shift_bit && bit_cnt != FULL_CNT) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end

         if (shift_bit) begin
            shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
         end

         // wdog reaching WDOG_MAX coincides with the timeout leaving the frame
         if (strobe || start_frame) begin
            wdog <= '0;
         end else if (in_frame && wdog != WDOG_MAX) begin
            wdog <= wdog + WDOG_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= stop_err || expire;
         overrun   <= complete && rx_valid && !rx_ready;
         busy      <= (state != IDLE);

         if (load) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule : uart_rx_framer

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: expected bytes queued as frames are sent and
// compared at each valid/ready handshake; pulse and timing checks inline.
module tb_uart_rx_framer;
   import definitions_pkg::*;

   localparam int DW = 8;
   localparam int T  = 2 * (CLOCK_RATE / BAUD_RATE);

   logic          clk;
   logic          rst_n;
   logic          baud;
   logic          line;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;
   int hs_cnt     = 0;
   int ferr_cnt   = 0;
   int ovr_cnt    = 0;
   int f0, o0, h0;
   bit tog_done   = 1'b0;
   logic [DW-1:0] sb[$];

   uart_rx_framer #(.DATA_BITS(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud      (baud),
      .line      (line),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // handshake monitor: a byte is consumed at the posedge following this negedge
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) ferr_cnt++;
         if (overrun)   ovr_cnt++;
         if (rx_valid && rx_ready) begin
            logic [DW-1:0] exp_b;
            hs_cnt++;
            if (sb.size() > 0) exp_b = sb.pop_front();
            else               exp_b = 'x;
            check("rx_data_handshake", 32'(rx_data), 32'(exp_b));
         end
      end
   end

   task automatic toggle_bit(input logic b);
      @(posedge clk);
      #1;
      line = b;
      baud = ~baud;
   endtask

   task automatic strobe_bit(input logic b);
      toggle_bit(b);
      repeat (3) @(posedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d);
      strobe_bit(1'b0);
      for (int i = 0; i < DW; i++) strobe_bit(d[i]);
   endtask

   initial begin
      rst_n    = 1'b0;
      baud     = 1'b0;
      line     = 1'b1;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_valid",  32'(rx_valid),  32'd0);
      check("reset_rx_data",   32'(rx_data),   32'd0);
      check("reset_busy",      32'(busy),      32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun",   32'(overrun),   32'd0);

      // baud differs from the cleared baud_q on release, with line low: must not start a frame
      baud  = 1'b1;
      line  = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("no_strobe_first_cycle_busy", 32'(busy), 32'd0);
      line = 1'b1;
      repeat (2) @(posedge clk);

      // 0xA5 with ready high: valid one cycle after stop strobe
      f0 = ferr_cnt; o0 = ovr_cnt; h0 = hs_cnt;
      sb.push_back(8'hA5);
      send_frame(8'hA5);
      check("a5_busy_in_frame", 32'(busy), 32'd1);
      toggle_bit(1'b1);
      #2;
      check("a5_valid_before_load", 32'(rx_valid), 32'd0);
      @(posedge clk);
      #1;
      check("a5_valid_latency", 32'(rx_valid), 32'd1);
      check("a5_rx_data",       32'(rx_data),  32'hA5);
      repeat (4) @(posedge clk);
      #1;
      check("a5_handshakes", 32'(hs_cnt - h0),   32'd1);
      check("a5_no_ferr",    32'(ferr_cnt - f0), 32'd0);
      check("a5_no_ovr",     32'(ovr_cnt - o0),  32'd0);

      // 0x3C with bad stop, held-low break, then line high
      f0 = ferr_cnt; h0 = hs_cnt;
      send_frame(8'h3C);
      toggle_bit(1'b0);
      @(posedge clk);
      #1;
      check("3c_stop_frame_err", 32'(frame_err), 32'd1);
      repeat (3) strobe_bit(1'b0);
      check("3c_busy_in_break", 32'(busy), 32'd1);
      strobe_bit(1'b1);
      check("3c_busy_after_high", 32'(busy),           32'd0);
      check("3c_ferr_pulses",     32'(ferr_cnt - f0),  32'd1);
      check("3c_rx_valid",        32'(rx_valid),       32'd0);
      check("3c_no_handshake",    32'(hs_cnt - h0),    32'd0);

      // 0x11 then 0x22 with ready low: overrun on the second, 0x11 held
      rx_ready = 1'b0;
      o0 = ovr_cnt; h0 = hs_cnt; f0 = ferr_cnt;
      sb.push_back(8'h11);
      send_frame(8'h11);
      strobe_bit(1'b1);
      send_frame(8'h22);
      toggle_bit(1'b1);
      @(posedge clk);
      #1;
      check("ovr_pulse",        32'(overrun), 32'd1);
      check("ovr_data_held",    32'(rx_data), 32'h11);
      @(posedge clk);
      #1;
      check("ovr_pulse_ended",  32'(overrun),  32'd0);
      check("ovr_valid_held",   32'(rx_valid), 32'd1);
      check("ovr_count",        32'(ovr_cnt - o0),  32'd1);
      check("ovr_no_ferr",      32'(ferr_cnt - f0), 32'd0);
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("ovr_one_handshake", 32'(hs_cnt - h0), 32'd1);
      check("ovr_valid_cleared", 32'(rx_valid),    32'd0);

      // strobe landing exactly on the watchdog expiry cycle keeps the frame alive
      f0 = ferr_cnt; h0 = hs_cnt;
      sb.push_back(8'h96);
      strobe_bit(1'b0);
      for (int i = 0; i < DW; i++) begin
         logic [DW-1:0] d;
         d = 8'h96;
         if (i == 3) repeat (T - 4) @(posedge clk);
         strobe_bit(d[i]);
      end
      strobe_bit(1'b1);
      check("wd_edge_no_ferr",   32'(ferr_cnt - f0), 32'd0);
      check("wd_edge_handshake", 32'(hs_cnt - h0),   32'd1);

      // start + 3 data strobes, then baud frozen
      f0 = ferr_cnt;
      strobe_bit(1'b0);
      strobe_bit(1'b1);
      strobe_bit(1'b0);
      toggle_bit(1'b1);
      @(posedge clk);
      repeat (T - 1) @(posedge clk);
      #1;
      check("timeout_not_early", 32'(frame_err), 32'd0);
      check("timeout_busy_pre",  32'(busy),      32'd1);
      @(posedge clk);
      #1;
      check("timeout_frame_err", 32'(frame_err), 32'd1);
      @(posedge clk);
      #1;
      check("timeout_busy_post",   32'(busy),          32'd0);
      check("timeout_pulse_ended", 32'(frame_err),     32'd0);
      check("timeout_ferr_count",  32'(ferr_cnt - f0), 32'd1);

      // reset in the middle of 0xFF, then 0x5A
      f0 = ferr_cnt; o0 = ovr_cnt; h0 = hs_cnt;
      strobe_bit(1'b0);
      repeat (4) strobe_bit(1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy",  32'(busy),     32'd0);
      check("rst_mid_valid", 32'(rx_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      sb.push_back(8'h5A);
      send_frame(8'h5A);
      strobe_bit(1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_no_ferr",       32'(ferr_cnt - f0), 32'd0);
      check("rst_no_ovr",        32'(ovr_cnt - o0),  32'd0);
      check("rst_one_handshake", 32'(hs_cnt - h0),   32'd1);

      // rx_ready toggling every cycle over four frames
      o0 = ovr_cnt; h0 = hs_cnt;
      for (int d = 1; d <= 4; d++) sb.push_back(DW'(d));
      fork
         begin
            for (int d = 1; d <= 4; d++) begin
               send_frame(DW'(d));
               strobe_bit(1'b1);
            end
            tog_done = 1'b1;
         end
         begin
            while (!tog_done) begin
               @(posedge clk);
               #1;
               rx_ready = ~rx_ready;
            end
         end
      join
      rx_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("toggle_handshakes", 32'(hs_cnt - h0), 32'd4);
      check("toggle_no_ovr",     32'(ovr_cnt - o0), 32'd0);
      check("scoreboard_empty",  32'(sb.size()),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_uart_rx_framer
